lcd_hex_writer: RTL

- Downstream consumer of the processor's user-interface outputs: drives the HD44780-compatible character LCD on the DE2 board.
- Shows two 32-bit words as 8 uppercase hex characters each: word 1 (instruction word) on row 1, word 2 (UI-selected debug value) on row 2.
- Runs the LCD power-up/init sequence once, then refreshes both rows continuously.
- Runs on the 50 MHz board clock, independent of the manual/slow processor clock.

---
 rtl/lcd_hex_writer_if.sv | 10 +
 rtl/lcd_hex_writer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/lcd_hex_writer_if.sv
// Write-only HD44780 character-LCD bus: 8-bit data, register select, enable strobe, read/write.
interface lcd_hex_writer_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_EN;
  logic       LCD_RW;

  modport master (output LCD_DATA, LCD_RS, LCD_EN, LCD_RW);
  modport slave  (input  LCD_DATA, LCD_RS, LCD_EN, LCD_RW);
endinterface

// File: rtl/lcd_hex_writer.sv
// Drives an HD44780 LCD: power-up wait, 4-command init, then endless refresh of two
// 32-bit words as 8 uppercase hex characters per row.
module lcd_hex_writer #(
  parameter int unsigned POWERUP_CYCLES    = 750000,
  parameter int unsigned EN_CYCLES         = 12,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       line1,
  input  logic [31:0]       line2,
  lcd_hex_writer_if.master  lcd,
  output logic              init_done,
  output logic              frame_done
);

  localparam int unsigned MAX_AB = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int unsigned MAX_CD = (EN_CYCLES > CMD_WAIT_CYCLES) ? EN_CYCLES : CMD_WAIT_CYCLES;
  localparam int unsigned MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    POWERUP, INIT, FRAME_START, SETUP, PULSE, HOLD, WAIT, NEXT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    byte_idx;
  logic [4:0]    next_idx;
  logic [31:0]   snap1;
  logic [31:0]   snap2;
  logic [7:0]    data_q;
  logic          rs_q;
  logic          en_q;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Returns {rs, data} for frame byte idx; ~n selects nibble 7-n so [31:28] goes first.
  function automatic logic [8:0] frame_byte(input logic [4:0] idx, input logic [31:0] s1,
                                            input logic [31:0] s2);
    logic [31:0] w;
    logic [2:0]  n;
    logic [3:0]  nib;
    w   = (idx <= 5'd8) ? s1 : s2;
    n   = (idx <= 5'd8) ? 3'(idx - 5'd1) : 3'(idx - 5'd10);
    nib = w[{~n, 2'b00} +: 4];
    case (idx)
      5'd0:    return {1'b0, 8'h80};
      5'd9:    return {1'b0, 8'hC0};
      default: return {1'b1, hex_char(nib)};
    endcase
  endfunction

  always_comb begin
    next_idx = byte_idx + 5'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= POWERUP;
      cnt        <= '0;
      byte_idx   <= '0;
      snap1      <= '0;
      snap2      <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        // The single INIT cycle is the last idle cycle of the power-up window.
        POWERUP: begin
          if (cnt == CW'(POWERUP_CYCLES - 2)) state <= INIT;
          else cnt <= cnt + 1'b1;
        end
        INIT: begin
          byte_idx <= '0;
          data_q   <= init_cmd(2'd0);
          rs_q     <= 1'b0;
          state    <= SETUP;
        end
        FRAME_START: begin
          snap1             <= line1;
          snap2             <= line2;
          byte_idx          <= '0;
          {rs_q, data_q}    <= frame_byte(5'd0, line1, line2);
          state             <= SETUP;
        end
        SETUP: begin
          en_q  <= 1'b1;
          cnt   <= CW'(EN_CYCLES - 1);
          state <= PULSE;
        end
        PULSE: begin
          if (cnt == '0) begin
            en_q  <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          cnt   <= (!rs_q && data_q == 8'h01) ? CW'(CLEAR_WAIT_CYCLES - 1) : CW'(CMD_WAIT_CYCLES - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!init_done) begin
            if (byte_idx == 5'd3) begin
              init_done <= 1'b1;
              state     <= FRAME_START;
            end else begin
              byte_idx <= next_idx;
              data_q   <= init_cmd(next_idx[1:0]);
              rs_q     <= 1'b0;
              state    <= SETUP;
            end
          end else if (byte_idx == 5'd17) begin
            frame_done <= 1'b1;
            state      <= NEXT;
          end else begin
            byte_idx       <= next_idx;
            {rs_q, data_q} <= frame_byte(next_idx, snap1, snap2);
            state          <= SETUP;
          end
        end
        NEXT:    state <= FRAME_START;
        default: state <= POWERUP;
      endcase
    end
  end

  assign lcd.LCD_DATA = data_q;
  assign lcd.LCD_RS   = rs_q;
  assign lcd.LCD_EN   = en_q;
  assign lcd.LCD_RW   = 1'b0;

endmodule
